afe_tot_readout: RTL and testbench
==================================

# afe_tot_readout

Multi-channel time-over-threshold (TOT) and hit capture block for the AFE CPLD, with an SPI slave for configuration and readout. Each of CHANNELS comparator inputs gets a hit flag and a CNT_W-bit TOT counter, gated by the injection window. Everything runs in the single CLK domain: COMP, INJ_IN and the SPI pins are synchronised and sampled. The SPI register map exposes a GPIO output register, per-channel counters and a hit status word.

## Interface
- CHANNELS, 4, number of comparator channels (1..16)
- CNT_W, 8, TOT counter width (2..16)
- GPIO_W, 8, GPIO register width (1..16)

- CLK  in  1  system clock; all state on rising edge
- RST_B  in  1  reset, synchronous, active-low
- SCLK  in  1  SPI clock, mode 0, max CLK/8
- MOSI  in  1  SPI data in, MSB first
- CS_B  in  1  SPI chip select, active-low
- MISO  out  1  SPI data out; 0 whenever CS_B is high
- INJ_IN  in  1  injection / measurement window, high = open
- INJ_OUT  out  1  combinational copy of INJ_IN
- COMP  in  CHANNELS  comparator outputs, asynchronous
- HIT  out  CHANNELS  per-channel hit flags
- GPIO  out  GPIO_W  general-purpose output register
- LED  out  1  high while any HIT bit is set

## Operation
- Synchronisation:
  - COMP, INJ_IN, SCLK, MOSI and CS_B each pass through a 2-FF synchroniser.
  - The internal names are comp_s, inj_s, sclk_s, mosi_s and cs_s.
- Window start (inj_s rising edge):
  - All HIT bits clear.
  - All counters clear to 0.
  - All overflow flags clear.
- While inj_s is 1:
  - HIT[i] sets on the first cycle comp_s[i] is 1 and holds until the next window start.
  - counter[i] increments on every CLK cycle comp_s[i] is 1.
- While inj_s is 0: counters and HIT bits hold their values, readable over SPI.
- Simultaneous inj_s rise and comp_s[i]=1: the clear wins for that cycle. Counting starts the following cycle.
- SPI frame:
  - A frame starts on the cs_s falling edge, which resets the bit counter.
  - Rising edge of sclk_s: shift in mosi_s.
  - Falling edge of sclk_s: shift out the next MISO bit.
  - Command byte (first 8 bits): bit7 = 1 write / 0 read; bits6:0 = address.
  - Data phase: 16 bits. Read values are zero-extended.
- Address map:
  - 0x00 GPIO: read/write.
  - 0x01..CHANNELS: counter[addr-1], read-only.
  - 0x7E: overflow flags, read-only.
  - 0x7F: HIT status, read-only.
  - Unmapped addresses read 0; writes to them are ignored.
- Read snapshot:
  - Taken on the 8th rising sclk_s edge.
  - Data MSB appears on MISO after the 8th falling edge.
  - Counting continues undisturbed during readout.
- Write commit:
  - A write commits to GPIO on the cs_s rising edge only if exactly 24 bits were received.
  - Any other count discards the write.
- Reset (RST_B=0 at a CLK edge):
  - All outputs are 0 except INJ_OUT: MISO, HIT, GPIO, LED.
  - Counters, overflow flags, shift registers and bit counter clear.
  - A frame in progress is aborted. The next frame needs CS_B high, then low.

## Timing
- HIT[i] rises 3 CLK edges after a COMP[i] rising edge, ±1 edge of sampling uncertainty.
- The counter value equals the number of CLK cycles comp_s[i] was high inside the window. It lags COMP by 2 cycles.
- LED follows the OR of HIT with 1 cycle of latency.
- MISO changes 3 CLK cycles after an SCLK falling edge. The master samples on the next SCLK rising edge; the CLK/8 limit guarantees setup.
- A GPIO write is visible 3 CLK cycles after the CS_B rising edge.
- INJ_OUT has zero-cycle combinational delay.

## Configuration
- AFE_TOT_SAT_EN defined:
  - Counters saturate at 2^CNT_W-1.
  - The overflow flag sets when an increment is attempted at saturation.
- AFE_TOT_SAT_EN undefined:
  - Counters wrap modulo 2^CNT_W.
  - The overflow flag sets on wrap.
  - Count continues after wrap.

## Test plan
- Reset: RST_B=0 for 2 cycles, with COMP toggling and INJ_IN=1.
  - Required: HIT=0, GPIO=0, MISO=0 and LED=0 during reset and on the first cycle after it.
- SPI write/read: write frame 0x80,0x00A5 to GPIO. Then read frame 0x00.
  - Required: GPIO=0xA5 after CS_B rise; MISO returns 0x00A5.
- TOT: INJ_IN high, COMP[2] high for exactly 20 CLK cycles. Then read address 0x03.
  - Required: 20 (±1); HIT=4'b0100; LED=1.
- Overflow, CNT_W=8: COMP[0] high for 300 cycles.
  - With the macro: counter[0]=255.
  - Without it: counter[0]=44.
  - Both builds: address 0x7E bit0=1.
- Aborted write: write frame truncated to 20 bits.
  - Required: GPIO unchanged.
- Reset mid-frame: RST_B asserted at bit 12 of a write frame.
  - Required: frame discarded; the next full frame is accepted.

Source files
------------

// File: rtl/afe_tot_readout.sv
// Multi-channel TOT counters and hit flags with an SPI (mode 0) register port.
// Define AFE_TOT_SAT_EN to make counters saturate instead of wrapping.
module afe_tot_readout #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int GPIO_W   = 8
) (
    input  logic                CLK,
    input  logic                RST_B,
    input  logic                SCLK,
    input  logic                MOSI,
    input  logic                CS_B,
    output logic                MISO,
    input  logic                INJ_IN,
    output logic                INJ_OUT,
    input  logic [CHANNELS-1:0] COMP,
    output logic [CHANNELS-1:0] HIT,
    output logic [GPIO_W-1:0]   GPIO,
    output logic                LED
);

    localparam int RX_W = (GPIO_W > 7) ? GPIO_W : 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] comp_m, comp_s;
    logic inj_m, inj_s, inj_d;
    logic sclk_m, sclk_s, sclk_d;
    logic mosi_m, mosi_s;
    logic cs_m, cs_s, cs_d;

    logic inj_rise;
    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] hit_q;
    logic                led_q;

    logic [5:0]        bit_cnt;
    logic [RX_W-1:0]   rx_sr;
    logic [15:0]       tx_sr;
    logic [7:0]        cmd;
    logic [7:0]        cmd_next;
    logic [15:0]       rd_data;
    logic              act;
    logic              miso_q;
    logic [GPIO_W-1:0] gpio_q;

    // Synchronisers are cleared too, so a CS_B held low through reset
    // never looks like a fresh frame start.
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            comp_m <= '0;
            comp_s <= '0;
            inj_m  <= 1'b0;
            inj_s  <= 1'b0;
            inj_d  <= 1'b0;
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_d <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            cs_m   <= 1'b0;
            cs_s   <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            comp_m <= COMP;
            comp_s <= comp_m;
            inj_m  <= INJ_IN;
            inj_s  <= inj_m;
            inj_d  <= inj_s;
            sclk_m <= SCLK;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            mosi_m <= MOSI;
            mosi_s <= mosi_m;
            cs_m   <= CS_B;
            cs_s   <= cs_m;
            cs_d   <= cs_s;
        end
    end

    assign inj_rise  = inj_s & ~inj_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            hit_q <= '0;
            ovf   <= '0;
            led_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            led_q <= |hit_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (inj_rise) begin
                    hit_q[i] <= 1'b0;
                    ovf[i]   <= 1'b0;
                    cnt[i]   <= '0;
                end else if (inj_s && comp_s[i]) begin
                    hit_q[i] <= 1'b1;
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end
`ifdef AFE_TOT_SAT_EN
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
`else
                    cnt[i] <= cnt[i] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Command byte as it stands once the 8th bit is shifted in.
    assign cmd_next = {rx_sr[6:0], mosi_s};

    always_comb begin
        rd_data = '0;
        if (cmd_next[6:0] == 7'h00) begin
            rd_data[GPIO_W-1:0] = gpio_q;
        end else if (cmd_next[6:0] == 7'h7E) begin
            rd_data[CHANNELS-1:0] = ovf;
        end else if (cmd_next[6:0] == 7'h7F) begin
            rd_data[CHANNELS-1:0] = hit_q;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cmd_next[6:0] == 7'(i + 1)) begin
                    rd_data[CNT_W-1:0] = cnt[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            act     <= 1'b0;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            cmd     <= '0;
            miso_q  <= 1'b0;
            gpio_q  <= '0;
        end else if (cs_s) begin
            act    <= 1'b0;
            miso_q <= 1'b0;
            if (cs_rise && act && bit_cnt == 6'd24 &&
                cmd[7] && cmd[6:0] == 7'h00) begin
                gpio_q <= rx_sr[GPIO_W-1:0];
            end
        end else if (cs_fall) begin
            act     <= 1'b1;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            cmd     <= '0;
            miso_q  <= 1'b0;
        end else if (act) begin
            if (sclk_rise) begin
                rx_sr <= {rx_sr[RX_W-2:0], mosi_s};
                // Saturate so over-long frames never alias to 24 bits.
                if (bit_cnt != 6'h3F) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
                if (bit_cnt == 6'd7) begin
                    cmd   <= cmd_next;
                    tx_sr <= rd_data;
                end
            end
            if (sclk_fall) begin
                if (bit_cnt >= 6'd8) begin
                    miso_q <= tx_sr[15];
                    tx_sr  <= {tx_sr[14:0], 1'b0};
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign MISO    = miso_q & ~CS_B;
    assign INJ_OUT = INJ_IN;
    assign HIT     = hit_q;
    assign GPIO    = gpio_q;
    assign LED     = led_q;

endmodule

// File: tb/tb_afe_tot_readout.sv
// Self-checking bench for afe_tot_readout: directed cases plus randomized
// measurement windows and SPI traffic against a behavioural model.
module tb_afe_tot_readout;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int GW   = 8;
    localparam int HP   = 5;
    localparam int MAXV = (1 << CW) - 1;

    logic          CLK    = 1'b0;
    logic          RST_B  = 1'b0;
    logic          SCLK   = 1'b0;
    logic          MOSI   = 1'b0;
    logic          CS_B   = 1'b1;
    logic          INJ_IN = 1'b0;
    logic [CH-1:0] COMP   = '0;
    logic          MISO;
    logic          INJ_OUT;
    logic [CH-1:0] HIT;
    logic [GW-1:0] GPIO;
    logic          LED;

    afe_tot_readout #(
        .CHANNELS(CH),
        .CNT_W(CW),
        .GPIO_W(GW)
    ) dut (
        .CLK(CLK),
        .RST_B(RST_B),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .CS_B(CS_B),
        .MISO(MISO),
        .INJ_IN(INJ_IN),
        .INJ_OUT(INJ_OUT),
        .COMP(COMP),
        .HIT(HIT),
        .GPIO(GPIO),
        .LED(LED)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: inputs become effective two clocks after sampling.
    int            mcnt [CH];
    logic [CH-1:0] mhit, movf;
    logic          mled;
    logic [GW-1:0] mgpio;
    logic [CH-1:0] dc1, dc2;
    logic          di1, di2, di3;

    always @(posedge CLK) begin
        if (!RST_B) begin
            for (int i = 0; i < CH; i++) mcnt[i] = 0;
            mhit  = '0;
            movf  = '0;
            mled  = 1'b0;
            mgpio = '0;
            dc1   = '0;
            dc2   = '0;
            di1   = 1'b0;
            di2   = 1'b0;
            di3   = 1'b0;
        end else begin
            mled = |mhit;
            if (di2 && !di3) begin
                mhit = '0;
                movf = '0;
                for (int i = 0; i < CH; i++) mcnt[i] = 0;
            end else if (di2) begin
                for (int i = 0; i < CH; i++) begin
                    if (dc2[i]) begin
                        int n;
                        mhit[i] = 1'b1;
                        n = mcnt[i] + 1;
                        if (n > MAXV) begin
                            movf[i] = 1'b1;
`ifdef AFE_TOT_SAT_EN
                            n = MAXV;
`else
                            n = n % (MAXV + 1);
`endif
                        end
                        mcnt[i] = n;
                    end
                end
            end
            di3 = di2;
            di2 = di1;
            di1 = INJ_IN;
            dc2 = dc1;
            dc1 = COMP;
        end
    end

    always @(negedge CLK) begin
        chk("hit", 32'(HIT), 32'(mhit));
        chk("led", 32'(LED), 32'(mled));
        chk("gpio", 32'(GPIO), 32'(mgpio));
        chk("inj_out", 32'(INJ_OUT), 32'(INJ_IN));
        if (CS_B) chk("miso_idle", 32'(MISO), 32'd0);
    end

    function automatic logic [15:0] exp_read(input logic [6:0] a);
        logic [15:0] r;
        r = '0;
        if (a == 7'h00) r = 16'(mgpio);
        else if (a == 7'h7E) r = 16'(movf);
        else if (a == 7'h7F) r = 16'(mhit);
        else
            for (int i = 0; i < CH; i++)
                if (a == 7'(i + 1)) r = 16'(mcnt[i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic spi_xfer(input logic [23:0] tx, input int nbits,
                            input int rst_at, output logic [15:0] rx);
        rx   = '0;
        CS_B = 1'b0;
        ticks(HP);
        for (int b = 0; b < nbits; b++) begin
            MOSI = tx[23-b];
            ticks(HP);
            if (b >= 8) rx = {rx[14:0], MISO};
            SCLK = 1'b1;
            ticks(HP);
            SCLK = 1'b0;
            if (b == rst_at) begin
                RST_B = 1'b0;
                ticks(2);
                RST_B = 1'b1;
            end
        end
        ticks(HP);
        CS_B = 1'b1;
        MOSI = 1'b0;
        if (nbits == 24 && tx[23] && tx[22:16] == 7'h00 && rst_at < 0) begin
            ticks(3);
            mgpio = tx[GW-1:0];
            ticks(HP);
        end else begin
            ticks(HP + 3);
        end
    endtask

    task automatic spi_read(input logic [6:0] a, output logic [15:0] rx);
        spi_xfer({1'b0, a, 16'h0000}, 24, -1, rx);
    endtask

    logic [15:0] rx;
    logic [6:0]  ra;

    initial begin
        // Reset with window open and comparators toggling
        RST_B  = 1'b0;
        INJ_IN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            COMP = (k == 0) ? 4'b1010 : 4'b0101;
            tick();
            chk("rst_hit", 32'(HIT), 32'd0);
            chk("rst_gpio", 32'(GPIO), 32'd0);
            chk("rst_miso", 32'(MISO), 32'd0);
            chk("rst_led", 32'(LED), 32'd0);
        end
        RST_B = 1'b1;
        COMP  = 4'b1111;
        tick();
        chk("post_rst_hit", 32'(HIT), 32'd0);
        chk("post_rst_gpio", 32'(GPIO), 32'd0);
        chk("post_rst_led", 32'(LED), 32'd0);
        ticks(6);
        INJ_IN = 1'b0;
        COMP   = '0;
        ticks(5);

        // GPIO write then readback
        spi_xfer(24'h8000A5, 24, -1, rx);
        chk("gpio_write", 32'(GPIO), 32'h0000_00A5);
        spi_read(7'h00, rx);
        chk("gpio_read", 32'(rx), 32'h0000_00A5);

        // 20-cycle pulse on channel 2
        INJ_IN = 1'b1;
        ticks(5);
        COMP = 4'b0100;
        ticks(20);
        COMP = '0;
        ticks(5);
        spi_read(7'h03, rx);
        chk("tot20_range", 32'(rx >= 16'd19 && rx <= 16'd21), 32'd1);
        chk("tot20_model", 32'(rx), 32'(mcnt[2]));
        chk("model_tot20", 32'(mcnt[2]), 32'd20);
        chk("tot_hit", 32'(HIT), 32'h4);
        chk("tot_led", 32'(LED), 32'd1);

        // 300-cycle pulse on channel 0 overflows an 8-bit counter
        INJ_IN = 1'b0;
        ticks(5);
        INJ_IN = 1'b1;
        ticks(5);
        COMP = 4'b0001;
        ticks(300);
        COMP = '0;
        ticks(5);
        spi_read(7'h01, rx);
`ifdef AFE_TOT_SAT_EN
        chk("ovf_cnt", 32'(rx), 32'd255);
        chk("model_ovf_cnt", 32'(mcnt[0]), 32'd255);
`else
        chk("ovf_cnt", 32'(rx), 32'd44);
        chk("model_ovf_cnt", 32'(mcnt[0]), 32'd44);
`endif
        spi_read(7'h7E, rx);
        chk("ovf_flag", 32'(rx[0]), 32'd1);
        chk("ovf_model", 32'(rx), 32'(exp_read(7'h7E)));
        INJ_IN = 1'b0;
        ticks(5);

        // Truncated write is discarded
        spi_xfer(24'h80005A, 20, -1, rx);
        chk("abort_write", 32'(GPIO), 32'h0000_00A5);

        // Reset mid-frame, then a full frame must be accepted
        spi_xfer(24'h80003C, 24, 12, rx);
        chk("rst_frame", 32'(GPIO), 32'd0);
        spi_xfer(24'h8000C3, 24, -1, rx);
        chk("after_rst_frame", 32'(GPIO), 32'h0000_00C3);

        // Randomized windows, reads and writes
        for (int w = 0; w < 8; w++) begin
            int len;
            len    = $urandom_range(30, 700);
            INJ_IN = 1'b1;
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(0, 3) == 0) COMP[i] = ~COMP[i];
                tick();
            end
            INJ_IN = 1'b0;
            ticks(3);
            COMP = 4'($urandom_range(0, 15));
            ticks(4);
            for (int a = 0; a < 7; a++) begin
                case (a)
                    0: ra = 7'h00;
                    5: ra = 7'h7E;
                    6: ra = 7'h7F;
                    default: ra = 7'(a);
                endcase
                spi_read(ra, rx);
                chk("rand_read", 32'(rx), 32'(exp_read(ra)));
            end
            ra = 7'($urandom_range(5, 125));
            spi_read(ra, rx);
            chk("rand_unmapped", 32'(rx), 32'd0);
            begin
                int nb;
                logic [6:0] wa;
                nb = ($urandom_range(0, 2) == 0) ? $urandom_range(16, 23) : 24;
                wa = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127))
                                                 : 7'h00;
                spi_xfer({1'b1, wa, 16'($urandom)}, nb, -1, rx);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
